// File: rtl/bool_fn_sweep.sv
// rtl/bool_fn_sweep.sv - multi-lane registered evaluator of F=(A^B)(C+~D) with truth-table sweep engine
module bool_fn_sweep #(
  parameter int LANES = 4,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_a,
  input  logic [LANES-1:0] in_b,
  input  logic [LANES-1:0] in_c,
  input  logic [LANES-1:0] in_d,
  input  logic             inv,
  output logic [LANES-1:0] f_out,
  output logic             out_valid,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [15:0]      tt,
  output logic [4:0]       ones
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic f_eval(input logic a, input logic b, input logic c, input logic d);
    return (a ^ b) & (c | ~d);
  endfunction

  // Stream path: stage 1 splits F into its two factors, stage 2 combines and applies inv.
  logic [LANES-1:0] s1_x_q, s1_y_q;
  logic             s1_inv_q, s1_vld_q;
  logic [LANES-1:0] f_q;
  logic             ov_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_inv_q <= 1'b0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_x_q   <= in_a ^ in_b;
        s1_y_q   <= in_c | ~in_d;
        s1_inv_q <= inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      ov_q <= s1_vld_q;
      if (s1_vld_q) begin
        f_q <= (s1_x_q & s1_y_q) ^ {LANES{s1_inv_q}};
      end
    end
  end

  assign f_out     = f_q;
  assign out_valid = ov_q;

  // Sweep engine
  logic [1:0]    state_q, state_d;
  logic [3:0]    v_q, v_d;
  logic [HW-1:0] h_q, h_d;
  logic          inv_s_q, inv_s_d;
  logic [15:0]   tt_q, tt_d;
  logic [4:0]    ones_q, ones_d;
  logic          cap_bit;

  assign cap_bit = f_eval(v_q[3], v_q[2], v_q[1], v_q[0]) ^ inv_s_q;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    h_d     = h_q;
    inv_s_d = inv_s_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SWEEP;
          inv_s_d = inv;
          v_d     = 4'd0;
          h_d     = '0;
          tt_d    = 16'h0000;
          ones_d  = 5'd0;
        end
      end
      ST_SWEEP: begin
        if (h_q == HOLD_M1) begin
          tt_d[v_q] = cap_bit;
          ones_d    = ones_q + {4'd0, cap_bit};
          h_d       = '0;
          v_d       = v_q + 4'd1;
          if (v_q == 4'd15) begin
            state_d = ST_DONE;
          end
        end else begin
          h_d = h_q + HW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      v_q     <= 4'd0;
      h_q     <= '0;
      inv_s_q <= 1'b0;
      tt_q    <= 16'h0000;
      ones_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      h_q     <= h_d;
      inv_s_q <= inv_s_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

  assign busy = (state_q == ST_SWEEP);
  assign done = (state_q == ST_DONE);
  assign tt   = tt_q;
  assign ones = ones_q;

endmodule

// File: tb/tb_bool_fn_sweep.sv
// tb/tb_bool_fn_sweep.sv - directed bench for bool_fn_sweep (HOLD=1 and HOLD=3 instances)
module tb_bool_fn_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1_n, rst3_n, in_valid, inv, start1, start3;
  logic [3:0] in_a, in_b, in_c, in_d;
  logic [3:0] f1, f3;
  logic       ov1, ov3, busy1, busy3, done1, done3;
  logic [15:0] tt1, tt3;
  logic [4:0] ones1, ones3;

  int checks = 0;
  int errors = 0;

  bool_fn_sweep #(.LANES(4), .HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .inv(inv),
    .f_out(f1), .out_valid(ov1), .start(start1), .busy(busy1), .done(done1),
    .tt(tt1), .ones(ones1)
  );

  bool_fn_sweep #(.LANES(4), .HOLD(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .inv(inv),
    .f_out(f3), .out_valid(ov3), .start(start3), .busy(busy3), .done(done3),
    .tt(tt3), .ones(ones3)
  );

  task automatic test_reset();
    @(negedge clk);
    rst1_n = 1'b0; rst3_n = 1'b0; in_valid = 1'b0; inv = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    in_a = 4'h0; in_b = 4'h0; in_c = 4'h0; in_d = 4'h0;
    @(negedge clk);
    checks++;
    if ({f1, ov1, busy1, done1, tt1, ones1} !== 28'd0) begin
      errors++;
      $display("FAIL reset1 got f=%h ov=%b busy=%b done=%b tt=%h ones=%0d, expected all 0", f1, ov1, busy1, done1, tt1, ones1);
    end
    checks++;
    if ({f3, ov3, busy3, done3, tt3, ones3} !== 28'd0) begin
      errors++;
      $display("FAIL reset3 got f=%h ov=%b busy=%b done=%b tt=%h ones=%0d, expected all 0", f3, ov3, busy3, done3, tt3, ones3);
    end
    rst1_n = 1'b1; rst3_n = 1'b1;
  endtask

  task automatic test_stream_lane0();
    logic [15:0] exp_tbl;
    logic [3:0]  vec;
    exp_tbl = 16'h0DD0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n >= 2 && n < 18) begin
        checks++;
        if (ov1 !== 1'b1 || f1 !== {3'b000, exp_tbl[n-2]}) begin
          errors++;
          $display("FAIL stream_v%0d got f=%b ov=%b, expected f=%b ov=1", n - 2, f1, ov1, {3'b000, exp_tbl[n-2]});
        end
      end else if (n >= 18) begin
        checks++;
        if (ov1 !== 1'b0 || f1 !== 4'b0000) begin
          errors++;
          $display("FAIL stream_tail got f=%b ov=%b, expected f=0000 ov=0", f1, ov1);
        end
      end
      if (n < 16) begin
        vec = 4'(n);
        in_a = {3'b000, vec[3]}; in_b = {3'b000, vec[2]};
        in_c = {3'b000, vec[1]}; in_d = {3'b000, vec[0]};
        inv = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_lanes_inv();
    @(negedge clk);
    in_a = 4'b0101; in_b = 4'b1110; in_c = 4'b1100; in_d = 4'b1010;
    inv = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; inv = 1'b0;
    @(negedge clk);
    checks++;
    if (f1 !== 4'b0110 || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL lanes_inv1 got f=%b ov=%b, expected f=0110 ov=1", f1, ov1);
    end
    checks++;
    if (f3 !== 4'b0110 || ov3 !== 1'b1) begin
      errors++;
      $display("FAIL lanes_inv3 got f=%b ov=%b, expected f=0110 ov=1", f3, ov3);
    end
    @(negedge clk);
    checks++;
    if (f1 !== 4'b0110 || ov1 !== 1'b0) begin
      errors++;
      $display("FAIL lanes_hold got f=%b ov=%b, expected f=0110 ov=0", f1, ov1);
    end
  endtask

  task automatic test_sweep_hold1();
    int busy_cnt, dn, guard;
    @(negedge clk);
    inv = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL sweep1_busy_start got busy=%b, expected 1", busy1);
    end
    busy_cnt = 0; dn = 0; guard = 0;
    while (busy1 === 1'b1 && guard < 200) begin
      if (busy_cnt == 8) begin
        checks++;
        if (tt1 !== 16'h00D0 || ones1 !== 5'd3) begin
          errors++;
          $display("FAIL sweep1_partial got tt=%h ones=%0d, expected tt=00d0 ones=3", tt1, ones1);
        end
      end
      if (done1 === 1'b1) dn++;
      busy_cnt++; guard++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 16 || dn != 0) begin
      errors++;
      $display("FAIL sweep1_busy_len got %0d cycles (done during busy %0d), expected 16 (0)", busy_cnt, dn);
    end
    checks++;
    if (done1 !== 1'b1 || tt1 !== 16'h0DD0 || ones1 !== 5'd6) begin
      errors++;
      $display("FAIL sweep1_result got done=%b tt=%h ones=%0d, expected done=1 tt=0dd0 ones=6", done1, tt1, ones1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0 || tt1 !== 16'h0DD0 || ones1 !== 5'd6) begin
      errors++;
      $display("FAIL sweep1_idle got done=%b busy=%b tt=%h ones=%0d, expected 0 0 0dd0 6", done1, busy1, tt1, ones1);
    end
  endtask

  task automatic test_sweep_hold3();
    int busy_cnt, dn, guard;
    @(negedge clk);
    inv = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    busy_cnt = 0; dn = 0; guard = 0;
    while (busy3 === 1'b1 && guard < 400) begin
      if (busy_cnt == 5)  inv = 1'b0;
      if (busy_cnt == 10) start3 = 1'b1;
      if (busy_cnt == 11) start3 = 1'b0;
      if (busy_cnt == 20) inv = 1'b1;
      if (busy_cnt == 30) inv = 1'b0;
      if (busy_cnt == 24) begin
        checks++;
        if (tt3 !== 16'h002F || ones3 !== 5'd5) begin
          errors++;
          $display("FAIL sweep3_partial got tt=%h ones=%0d, expected tt=002f ones=5", tt3, ones3);
        end
      end
      if (done3 === 1'b1) dn++;
      busy_cnt++; guard++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 48) begin
      errors++;
      $display("FAIL sweep3_busy_len got %0d cycles, expected 48", busy_cnt);
    end
    checks++;
    if (done3 !== 1'b1 || tt3 !== 16'hF22F || ones3 !== 5'd10) begin
      errors++;
      $display("FAIL sweep3_result got done=%b tt=%h ones=%0d, expected done=1 tt=f22f ones=10", done3, tt3, ones3);
    end
    for (int i = 0; i < 6; i++) begin
      if (done3 === 1'b1) dn++;
      if (busy3 === 1'b1) dn += 100;
      @(negedge clk);
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL sweep3_single_done got code %0d, expected 1 (one done, no restart)", dn);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cnt, dn, guard;
    @(negedge clk);
    inv = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    busy_cnt = 0; guard = 0;
    while (busy1 === 1'b1 && busy_cnt < 7 && guard < 50) begin
      busy_cnt++; guard++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 7 || tt1 !== 16'h0050 || ones1 !== 5'd2) begin
      errors++;
      $display("FAIL midrst_partial got cnt=%0d tt=%h ones=%0d, expected cnt=7 tt=0050 ones=2", busy_cnt, tt1, ones1);
    end
    rst1_n = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || tt1 !== 16'h0000 || ones1 !== 5'd0) begin
      errors++;
      $display("FAIL midrst_clear got busy=%b done=%b tt=%h ones=%0d, expected 0 0 0000 0", busy1, done1, tt1, ones1);
    end
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done1 === 1'b1 || busy1 === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL midrst_nodone got %0d active cycles, expected 0", dn);
    end
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    guard = 0;
    while (busy1 === 1'b1 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    checks++;
    if (guard != 16 || done1 !== 1'b1 || tt1 !== 16'h0DD0 || ones1 !== 5'd6) begin
      errors++;
      $display("FAIL midrst_rerun got len=%0d done=%b tt=%h ones=%0d, expected 16 1 0dd0 6", guard, done1, tt1, ones1);
    end
  endtask

  task automatic test_stream_during_sweep();
    int         vec_tbl [8];
    logic [3:0] exp_f [8];
    logic       exp_v [8];
    logic [3:0] vec;
    int         guard;
    vec_tbl = '{4, 8, 5, 8, 7, 8, 9, 8};
    exp_f   = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
    exp_v   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    inv = 1'b0; start1 = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (n >= 2) begin
        checks++;
        if (f1 !== exp_f[n-2] || ov1 !== exp_v[n-2]) begin
          errors++;
          $display("FAIL sweepstream_b%0d got f=%b ov=%b, expected f=%b ov=%b", n - 2, f1, ov1, exp_f[n-2], exp_v[n-2]);
        end
      end
      if (n < 8) begin
        vec = 4'(vec_tbl[n]);
        in_a = {4{vec[3]}}; in_b = {4{vec[2]}}; in_c = {4{vec[1]}}; in_d = {4{vec[0]}};
        in_valid = ((n % 2) == 0);
        inv = (n == 3);
      end else begin
        in_valid = 1'b0; inv = 1'b0;
      end
    end
    guard = 0;
    while (busy1 === 1'b1 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    checks++;
    if (done1 !== 1'b1 || tt1 !== 16'h0DD0 || ones1 !== 5'd6) begin
      errors++;
      $display("FAIL sweepstream_result got done=%b tt=%h ones=%0d, expected 1 0dd0 6", done1, tt1, ones1);
    end
  endtask

  initial begin
    rst1_n = 1'b0; rst3_n = 1'b0; in_valid = 1'b0; inv = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    in_a = 4'h0; in_b = 4'h0; in_c = 4'h0; in_d = 4'h0;
    test_reset();
    test_stream_lane0();
    test_lanes_inv();
    test_sweep_hold1();
    test_sweep_hold3();
    test_reset_mid_sweep();
    test_stream_during_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
